// File: rtl/regfile_access_ctrl.sv
`timescale 1ns/1ps
// Command front-end for the 8x16 register file: sequences WrEn/RdEn/Address/WrData
// from valid/ready commands and returns read data on a valid/ready response channel.
module regfile_access_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [DATA_WIDTH-1:0] rf_WrData,
    output logic [ADDR_WIDTH-1:0] rf_Address,
    output logic                  rf_WrEn,
    output logic                  rf_RdEn,
    input  logic [DATA_WIDTH-1:0] rf_RdData,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        READ    = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [DATA_WIDTH-1:0]   rsp_data_q;
    logic                    accept;

    assign accept = cmd_valid && cmd_ready;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The register file's RdData is registered, so it is only valid in CAPTURE.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            addr_q     <= '0;
            data_q     <= '0;
            rsp_data_q <= '0;
        end else begin
            if (accept) begin
                addr_q <= cmd_addr;
                data_q <= cmd_data;
            end
            if (state == CAPTURE) begin
                rsp_data_q <= rf_RdData;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rf_WrEn   = 1'b0;
        rf_RdEn   = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                // Hold off commands while reset is asserted.
                cmd_ready = RST;
                if (cmd_valid && RST) begin
                    state_nxt = cmd_op ? WRITE : READ;
                end
            end
            WRITE: begin
                rf_WrEn   = 1'b1;
                state_nxt = IDLE;
            end
            READ: begin
                rf_RdEn   = 1'b1;
                state_nxt = CAPTURE;
            end
            CAPTURE: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign rf_Address = addr_q;
    assign rf_WrData  = data_q;
    assign rsp_data   = rsp_data_q;
    assign busy       = (state != IDLE);

endmodule
